// File: rtl/coin_dispenser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coin_dispenser_pkg
//  Purpose  : Shared types for the coin dispenser: FSM state encoding, the
//             change-code width and the buffered vend-request record.
//  Revision : 1.0 - initial release
// ============================================================================
package coin_dispenser_pkg;

  localparam int CHANGE_W = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SODA     = 3'd1,
    COIN_ON  = 3'd2,
    COIN_OFF = 3'd3,
    DONE     = 3'd4
  } disp_state_e;

  typedef struct packed {
    logic                soda;
    logic [CHANGE_W-1:0] nickels;
  } disp_req_t;

endpackage : coin_dispenser_pkg
`default_nettype wire

// File: rtl/coin_dispenser_pending_slot.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pending_slot
//  Purpose  : One-entry holding register for a vend request that arrives
//             while the dispenser is busy. A push and a pop in the same cycle
//             replaces the stored entry.
//  Ports    : i_clk   - clock, rising edge
//             i_rst_n - asynchronous active-low reset
//             i_push  - store i_req (caller only pushes when there is room)
//             i_pop   - consume the stored entry
//             i_req   - request to store
//             o_full  - an entry is held
//             o_req   - the stored entry
//  Revision : 1.0 - initial release
// ============================================================================
module disp_pending_slot
  import coin_dispenser_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  disp_req_t i_req,
  output logic      o_full,
  output disp_req_t o_req
);

  logic      r_valid;
  disp_req_t r_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (i_push) begin
      // Push wins over pop: a simultaneous push+pop leaves the new entry held.
      r_valid <= 1'b1;
      r_req   <= i_req;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_full = r_valid;
  assign o_req  = r_req;

endmodule : disp_pending_slot
`default_nettype wire

// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : coin_dispenser
//  Purpose  : Turns one-cycle vend requests (soda + nickel count) into timed
//             actuator drives: soda motor first, then one pulse per nickel
//             with a recovery gap after each. One request can wait while busy.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_soda, i_change[2:0] - request strobe and nickel count
//             o_busy, o_soda_drive, o_nickel_drive - status / actuator enables
//             o_done, o_err, o_overrun - one-cycle event pulses
//  Revision : 1.0 - initial release
// ============================================================================
module coin_dispenser
  import coin_dispenser_pkg::*;
#(
  parameter int SODA_CYC    = 4,
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 2,
  parameter int MAX_NICKELS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_soda,
  input  logic [CHANGE_W-1:0] i_change,
  output logic                o_busy,
  output logic                o_soda_drive,
  output logic                o_nickel_drive,
  output logic                o_done,
  output logic                o_err,
  output logic                o_overrun
);

  localparam int MAX_A = (SODA_CYC > PULSE_CYC) ? SODA_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  disp_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CHANGE_W-1:0] r_nick, w_nick_nxt;

  logic                w_illegal, w_req, w_take_in, w_start, w_pop, w_push, w_overrun;
  logic                w_slot_full;
  disp_req_t           w_in_req, w_slot_req, w_start_req;

  // Illegal codes are flagged and then behave as "no change".
  assign w_illegal        = (i_change > CHANGE_W'(MAX_NICKELS));
  assign w_in_req.soda    = i_soda;
  assign w_in_req.nickels = w_illegal ? '0 : i_change;
  assign w_req            = i_soda | (w_in_req.nickels != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_nick_nxt  = r_nick;
    w_pop       = 1'b0;
    w_take_in   = 1'b0;
    w_start     = 1'b0;
    w_start_req = w_in_req;
    case (r_state)
      IDLE: begin
        // A held entry (left by a request that landed in DONE) goes first.
        if (w_slot_full) begin
          w_pop       = 1'b1;
          w_start     = 1'b1;
          w_start_req = w_slot_req;
        end else if (w_req) begin
          w_take_in = 1'b1;
          w_start   = 1'b1;
        end
      end
      SODA: begin
        if (r_cnt == '0) w_state_nxt = (r_nick != '0) ? COIN_ON : DONE;
      end
      COIN_ON: begin
        if (r_cnt == '0) w_state_nxt = COIN_OFF;
      end
      COIN_OFF: begin
        if (r_cnt == '0) begin
          w_nick_nxt  = r_nick - 1'b1;
          w_state_nxt = (r_nick > CHANGE_W'(1)) ? COIN_ON : DONE;
        end
      end
      DONE: begin
        if (w_slot_full) begin
          w_pop       = 1'b1;
          w_start     = 1'b1;
          w_start_req = w_slot_req;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_start) begin
      w_nick_nxt  = w_start_req.nickels;
      w_state_nxt = w_start_req.soda ? SODA : COIN_ON;
    end
  end

  // Duration counter: reload on every state entry, count down to zero, hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        SODA:     w_cnt_nxt = CNT_W'(SODA_CYC - 1);
        COIN_ON:  w_cnt_nxt = CNT_W'(PULSE_CYC - 1);
        COIN_OFF: w_cnt_nxt = CNT_W'(GAP_CYC - 1);
        default:  w_cnt_nxt = '0;
      endcase
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // A request not started directly is buffered if the slot has room or is
  // being emptied at this same edge; otherwise it is dropped.
  assign w_push    = w_req & ~w_take_in & (~w_slot_full | w_pop);
  assign w_overrun = w_req & ~w_take_in & w_slot_full & ~w_pop;

  disp_pending_slot u_slot (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_req   (w_in_req),
    .o_full  (w_slot_full),
    .o_req   (w_slot_req)
  );

  // Outputs are decoded from the next state so every output is a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_nick         <= '0;
      o_busy         <= 1'b0;
      o_soda_drive   <= 1'b0;
      o_nickel_drive <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_nick         <= w_nick_nxt;
      o_busy         <= (w_state_nxt != IDLE);
      o_soda_drive   <= (w_state_nxt == SODA);
      o_nickel_drive <= (w_state_nxt == COIN_ON);
      o_done         <= (w_state_nxt == DONE);
      o_err          <= w_illegal;
      o_overrun      <= w_overrun;
    end
  end

endmodule : coin_dispenser
`default_nettype wire
